// File: rtl/chip8_call_ret_unit.sv
// CHIP-8 subroutine call/return sequencer. Turns a 2NNN call or 00EE return
// request into exactly one stack command, tracks stack depth, rejects calls
// on a full stack and returns on an empty one, and hands the CPU a new PC.

package chip8_call_ret_pkg;
  typedef enum logic [1:0] {
    STACK_HOLD = 2'd0,
    STACK_PUSH = 2'd1,
    STACK_POP  = 2'd2
  } stack_op_t;
endpackage

module chip8_call_ret_unit #(
  parameter int POP_LAT = 1,  // stack read latency after a POP, 1..4
  parameter int DEPTH   = 16  // stack capacity in entries
) (
  input  logic                          cpu_clk,
  input  logic                          reset,
  input  logic                          req_call,
  input  logic                          req_ret,
  input  logic [11:0]                   call_target,
  input  logic [11:0]                   pc_in,
  output chip8_call_ret_pkg::stack_op_t stk_op,
  output logic [15:0]                   stk_writedata,
  input  logic [15:0]                   stk_outdata,
  output logic                          busy,
  output logic                          done,
  output logic                          pc_load,
  output logic [11:0]                   pc_out,
  output logic                          err_overflow,
  output logic                          err_underflow,
  output logic [4:0]                    depth
);
  import chip8_call_ret_pkg::*;

  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);
  localparam logic [1:0] WAIT_LAST = 2'(POP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  depth_q, depth_d;
  logic [11:0] target_q, target_d;   // latched call destination
  logic [11:0] pc_q, pc_d;           // latched address of the calling instruction
  logic [11:0] pc_out_q, pc_out_d;   // call target or popped return address
  logic        ovf_q, ovf_d;         // which error the ERR state reports
  logic [1:0]  wait_cnt_q, wait_cnt_d;

  // The stack stores full 16-bit words; only the 12-bit address is meaningful.
  logic unused_outdata_hi;
  assign unused_outdata_hi = ^stk_outdata[15:12];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge cpu_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      depth_q    <= '0;
      target_q   <= '0;
      pc_q       <= '0;
      pc_out_q   <= '0;
      ovf_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      target_q   <= target_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      ovf_q      <= ovf_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    state_d       = state_q;
    depth_d       = depth_q;
    target_d      = target_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    ovf_d         = ovf_q;
    wait_cnt_d    = wait_cnt_q;
    stk_op        = STACK_HOLD;
    stk_writedata = '0;
    done          = 1'b0;
    pc_load       = 1'b0;
    err_overflow  = 1'b0;
    err_underflow = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A call wins over a simultaneous return.
        if (req_call) begin
          target_d = call_target;
          pc_d     = pc_in;
          ovf_d    = 1'b1;
          state_d  = (depth_q < DEPTH_MAX) ? S_PUSH : S_ERR;
        end else if (req_ret) begin
          ovf_d   = 1'b0;
          state_d = (depth_q != '0) ? S_POP : S_ERR;
        end
      end
      S_PUSH: begin
        stk_op        = STACK_PUSH;
        stk_writedata = {4'h0, pc_q + 12'd2};  // wraps modulo 4 KiB
        depth_d       = depth_q + 5'd1;
        pc_out_d      = target_q;
        state_d       = S_DONE;
      end
      S_POP: begin
        stk_op     = STACK_POP;
        depth_d    = depth_q - 5'd1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          pc_out_d = stk_outdata[11:0];
          state_d  = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        pc_load = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done          = 1'b1;
        err_overflow  = ovf_q;
        err_underflow = ~ovf_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign pc_out = pc_out_q;
  assign depth  = depth_q;

endmodule

// File: tb/tb_chip8_call_ret_unit.sv
// Bench for chip8_call_ret_unit: a behavioural stack with read latency sits
// on the stack port, and a queue of expected return addresses predicts every
// PC, latency, error pulse and depth.

module tb_chip8_call_ret_unit;
  import chip8_call_ret_pkg::*;

  localparam int P_LAT = 2;
  localparam int DEPTH = 16;

  logic        cpu_clk;
  logic        reset;
  logic        req_call;
  logic        req_ret;
  logic [11:0] call_target;
  logic [11:0] pc_in;
  stack_op_t   stk_op;
  logic [15:0] stk_writedata;
  logic [15:0] stk_outdata;
  logic        busy;
  logic        done;
  logic        pc_load;
  logic [11:0] pc_out;
  logic        err_overflow;
  logic        err_underflow;
  logic [4:0]  depth;

  int n_pass  = 0;
  int n_total = 0;

  // Reference: expected return addresses, top at the back, and the last PC handed out.
  logic [11:0] ref_ret[$];
  logic [11:0] ref_pc;

  chip8_call_ret_unit #(.POP_LAT(P_LAT), .DEPTH(DEPTH)) dut (
    .cpu_clk       (cpu_clk),
    .reset         (reset),
    .req_call      (req_call),
    .req_ret       (req_ret),
    .call_target   (call_target),
    .pc_in         (pc_in),
    .stk_op        (stk_op),
    .stk_writedata (stk_writedata),
    .stk_outdata   (stk_outdata),
    .busy          (busy),
    .done          (done),
    .pc_load       (pc_load),
    .pc_out        (pc_out),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .depth         (depth)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Stack model: popped data shows corrupted until P_LAT-1 edges after the POP edge.
  logic [15:0] stk_mem[$];
  logic [15:0] stk_pending;
  int          stk_lat;
  always @(posedge cpu_clk) begin
    if (reset) begin
      stk_mem.delete();
      stk_lat = 0;
      stk_outdata <= 16'h0000;
    end else if (stk_op == STACK_PUSH) begin
      stk_mem.push_back(stk_writedata);
    end else if (stk_op == STACK_POP) begin
      stk_pending = (stk_mem.size() > 0) ? stk_mem.pop_back() : 16'hBEEF;
      stk_lat = P_LAT - 1;
      stk_outdata <= (stk_lat == 0) ? stk_pending : (stk_pending ^ 16'h0F0F);
    end else if (stk_lat > 0) begin
      if (stk_lat == 1) stk_outdata <= stk_pending;
      stk_lat = stk_lat - 1;
    end
  end

  task automatic apply_reset(input int cycles);
    @(negedge cpu_clk);
    reset = 1'b1; req_call = 1'b0; req_ret = 1'b0;
    repeat (cycles) @(negedge cpu_clk);
    reset = 1'b0;
    ref_ret.delete();
    ref_pc = 12'h000;
  endtask

  // Issue one request and predict everything observable over an 8-cycle window.
  task automatic run_req(input logic call, input logic ret, input logic [11:0] pc,
                         input logic [11:0] tgt, input logic poke_ret);
    logic        ok;
    int          exp_lat;
    logic [11:0] exp_pc;
    logic [15:0] exp_wd;
    int          done_at, n_done, n_load, n_push, n_pop, n_stray;
    logic        saw_ovf, saw_unf, busy_k1;
    logic [11:0] pc_seen;
    logic [15:0] wd_seen;

    ok      = call ? (ref_ret.size() < DEPTH) : (ref_ret.size() > 0);
    exp_lat = !ok ? 1 : (call ? 2 : 2 + P_LAT);
    exp_pc  = !ok ? ref_pc : (call ? tgt : ref_ret[$]);
    exp_wd  = {4'h0, 12'((int'(pc) + 2) % 4096)};
    done_at = -1; n_done = 0; n_load = 0; n_push = 0; n_pop = 0; n_stray = 0;
    saw_ovf = 1'b0; saw_unf = 1'b0; busy_k1 = 1'b0;
    pc_seen = 12'h000; wd_seen = 16'h0000;

    @(negedge cpu_clk);
    req_call = call; req_ret = ret; pc_in = pc; call_target = tgt;
    for (int k = 1; k <= 8; k++) begin
      @(negedge cpu_clk);
      if (k == 1) begin
        busy_k1 = busy;
        req_call = 1'b0; req_ret = poke_ret;
        pc_in = 12'($urandom); call_target = 12'($urandom);
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = k;
        pc_seen = pc_out;
        if (pc_load) n_load++;
        if (err_overflow) saw_ovf = 1'b1;
        if (err_underflow) saw_unf = 1'b1;
        req_ret = 1'b0;
      end else if (pc_load || err_overflow || err_underflow) begin
        n_stray++;
      end
      if (stk_op == STACK_PUSH) begin n_push++; wd_seen = stk_writedata; end
      if (stk_op == STACK_POP) n_pop++;
    end
    req_ret = 1'b0;

    n_total++;
    if (busy_k1 !== 1'b1) $display("FAIL busy_after_req: got %b want 1", busy_k1);
    else n_pass++;
    n_total++;
    if (done_at != exp_lat) $display("FAIL done_latency: got %0d want %0d (call=%b)", done_at, exp_lat, call);
    else n_pass++;
    n_total++;
    if (n_done != 1) $display("FAIL done_pulses: got %0d want 1", n_done);
    else n_pass++;
    n_total++;
    if (n_load != int'(ok)) $display("FAIL pc_load_pulses: got %0d want %0d", n_load, int'(ok));
    else n_pass++;
    n_total++;
    if (saw_ovf !== (!ok && call) || saw_unf !== (!ok && !call))
      $display("FAIL err_flags: got ovf=%b unf=%b want ovf=%b unf=%b", saw_ovf, saw_unf, !ok && call, !ok && !call);
    else n_pass++;
    n_total++;
    if (n_stray != 0) $display("FAIL stray_pulses: got %0d want 0", n_stray);
    else n_pass++;
    n_total++;
    if (n_push != int'(ok && call) || n_pop != int'(ok && !call))
      $display("FAIL stack_cmds: got push=%0d pop=%0d want push=%0d pop=%0d", n_push, n_pop, int'(ok && call), int'(ok && !call));
    else n_pass++;
    if (ok && call) begin
      n_total++;
      if (wd_seen !== exp_wd) $display("FAIL push_data: got %h want %h", wd_seen, exp_wd);
      else n_pass++;
    end
    if (ok) begin
      n_total++;
      if (pc_seen !== exp_pc) $display("FAIL pc_out_at_done: got %h want %h", pc_seen, exp_pc);
      else n_pass++;
      if (call) ref_ret.push_back(12'((int'(pc) + 2) % 4096));
      else void'(ref_ret.pop_back());
      ref_pc = exp_pc;
    end
    n_total++;
    if (depth !== 5'(ref_ret.size())) $display("FAIL depth: got %0d want %0d", depth, ref_ret.size());
    else n_pass++;
    n_total++;
    if (pc_out !== ref_pc || busy !== 1'b0)
      $display("FAIL idle_hold: got pc_out=%h busy=%b want pc_out=%h busy=0", pc_out, busy, ref_pc);
    else n_pass++;
  endtask

  task automatic test_reset;
    apply_reset(3);
    n_total++;
    if (depth !== 5'd0 || stk_op !== STACK_HOLD || stk_writedata !== 16'h0000 || pc_out !== 12'h000 ||
        busy !== 1'b0 || done !== 1'b0 || pc_load !== 1'b0 || err_overflow !== 1'b0 || err_underflow !== 1'b0)
      $display("FAIL reset_state: got depth=%0d op=%0d wd=%h pc=%h busy=%b done=%b load=%b ovf=%b unf=%b want all zero/HOLD",
               depth, stk_op, stk_writedata, pc_out, busy, done, pc_load, err_overflow, err_underflow);
    else n_pass++;
  endtask

  task automatic test_call;
    apply_reset(2);
    run_req(1'b1, 1'b0, 12'h200, 12'h300, 1'b0);
  endtask

  task automatic test_nested;
    apply_reset(2);
    run_req(1'b1, 1'b0, 12'h200, 12'($urandom), 1'b0);
    run_req(1'b1, 1'b0, 12'h400, 12'($urandom), 1'b0);
    run_req(1'b1, 1'b0, 12'h600, 12'($urandom), 1'b0);
    run_req(1'b0, 1'b1, 12'($urandom), 12'($urandom), 1'b0);  // expects 0x602
    run_req(1'b0, 1'b1, 12'($urandom), 12'($urandom), 1'b0);  // expects 0x402
    run_req(1'b0, 1'b1, 12'($urandom), 12'($urandom), 1'b0);  // expects 0x202
  endtask

  task automatic test_overflow;
    apply_reset(2);
    for (int i = 0; i < DEPTH; i++) run_req(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b0);
    run_req(1'b1, 1'b0, 12'h123, 12'h456, 1'b0);
  endtask

  task automatic test_underflow;
    apply_reset(2);
    run_req(1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
  endtask

  task automatic test_simultaneous;
    apply_reset(2);
    run_req(1'b1, 1'b1, 12'hFFE, 12'h5A5, 1'b0);
    run_req(1'b1, 1'b0, 12'h310, 12'h700, 1'b1);  // return held while busy is ignored
    run_req(1'b0, 1'b1, 12'h000, 12'h000, 1'b1);
  endtask

  task automatic test_reset_in_wait;
    int n_done;
    apply_reset(2);
    run_req(1'b1, 1'b0, 12'h240, 12'h800, 1'b0);
    n_done = 0;
    @(negedge cpu_clk);
    req_ret = 1'b1;
    @(negedge cpu_clk);  // POP cycle
    req_ret = 1'b0;
    if (done) n_done++;
    @(negedge cpu_clk);  // first WAIT cycle
    if (done) n_done++;
    n_total++;
    if (stk_op !== STACK_HOLD || busy !== 1'b1)
      $display("FAIL wait_state: got op=%0d busy=%b want HOLD busy=1", stk_op, busy);
    else n_pass++;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge cpu_clk);
      if (k == 1) reset = 1'b0;
      if (done || pc_load) n_done++;
    end
    ref_ret.delete();
    ref_pc = 12'h000;
    n_total++;
    if (n_done != 0) $display("FAIL reset_abort_done: got %0d pulses want 0", n_done);
    else n_pass++;
    n_total++;
    if (depth !== 5'd0 || busy !== 1'b0 || pc_out !== 12'h000)
      $display("FAIL reset_abort_state: got depth=%0d busy=%b pc=%h want 0/0/000", depth, busy, pc_out);
    else n_pass++;
    run_req(1'b1, 1'b0, 12'h500, 12'h9AB, 1'b0);
  endtask

  task automatic test_random;
    apply_reset(2);
    for (int i = 0; i < 60; i++) begin
      logic c, r;
      c = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 60);
      if (!c && !r) r = 1'b1;
      run_req(c, r, 12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)));
    end
    while (ref_ret.size() > 0) run_req(1'b0, 1'b1, 12'($urandom), 12'($urandom), 1'b0);
    run_req(1'b0, 1'b1, 12'($urandom), 12'($urandom), 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_call = 1'b0; req_ret = 1'b0;
    call_target = 12'h000; pc_in = 12'h000;
    ref_pc = 12'h000;
    test_reset;
    test_call;
    test_nested;
    test_overflow;
    test_underflow;
    test_simultaneous;
    test_reset_in_wait;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
